// File: rtl/dpll_loop_filter_if.sv
// Signal bundle between the phase detector / telemetry side (master) and the
// PI loop filter (slave).
interface dpll_loop_filter_if;
    logic signed [15:0] phase_error;
    logic               hold;
    logic        [31:0] freq_word;
    logic               freq_update;
    logic signed [31:0] integ_out;
    logic               locked;

    modport master (
        output phase_error, hold,
        input  freq_word, freq_update, integ_out, locked
    );

    modport slave (
        input  phase_error, hold,
        output freq_word, freq_update, integ_out, locked
    );
endinterface

// File: rtl/dpll_loop_filter.sv
// PI loop filter for the DPLL: error events -> saturated 32-bit NCO tuning word.
// Define LF_LOCK_DET_EN to build the sign-alternation lock detector.
module dpll_loop_filter #(
    parameter logic [31:0] CENTER_WORD = 32'd85899346,
    parameter int unsigned KP_SHIFT    = 8,
    parameter int unsigned KI_SHIFT    = 2,
    parameter logic [31:0] INT_LIMIT   = 32'd4194304,
    parameter logic [31:0] FREQ_MIN    = 32'd42949673,
    parameter logic [31:0] FREQ_MAX    = 32'd171798692,
    parameter int unsigned LOCK_COUNT  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    dpll_loop_filter_if.slave  lf
);
    localparam logic signed [33:0] INT_HI   = $signed({2'b00, INT_LIMIT});
    localparam logic signed [33:0] INT_LO   = -INT_HI;
    localparam logic signed [33:0] F_MIN    = $signed({2'b00, FREQ_MIN});
    localparam logic signed [33:0] F_MAX    = $signed({2'b00, FREQ_MAX});
    localparam logic signed [33:0] CENTER34 = $signed({2'b00, CENTER_WORD});

    logic               ev;
    logic               ev_pending;
    logic signed [31:0] pe_ext;
    logic signed [31:0] prop_reg;
    logic signed [31:0] prop_next;
    logic signed [31:0] integ_reg;
    logic signed [31:0] integ_next;
    logic signed [31:0] integ_step;
    logic signed [33:0] integ_sum;
    logic signed [33:0] freq_sum;
    logic        [31:0] freq_next;
    logic        [31:0] freq_reg;
    logic               update_reg;

    always_comb begin
        ev         = (lf.phase_error != '0) && !lf.hold;
        pe_ext     = {{16{lf.phase_error[15]}}, lf.phase_error};
        prop_next  = pe_ext <<< KP_SHIFT;
        integ_step = pe_ext <<< KI_SHIFT;
        // Widened to 34 bits so the clamp sees the true sum, never a wrapped one
        integ_sum  = {{2{integ_reg[31]}}, integ_reg} + {{2{integ_step[31]}}, integ_step};
        if (integ_sum > INT_HI)
            integ_next = INT_HI[31:0];
        else if (integ_sum < INT_LO)
            integ_next = INT_LO[31:0];
        else
            integ_next = integ_sum[31:0];

        freq_sum = CENTER34 + {{2{prop_reg[31]}}, prop_reg} + {{2{integ_reg[31]}}, integ_reg};
        if (freq_sum > F_MAX)
            freq_next = FREQ_MAX;
        else if (freq_sum < F_MIN)
            freq_next = FREQ_MIN;
        else
            freq_next = freq_sum[31:0];
    end

    // Stage 1 latches the event; stage 2 (one edge later) reloads freq_word.
    // A pending stage-2 reload completes even if hold rises in between.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prop_reg   <= '0;
            integ_reg  <= '0;
            ev_pending <= 1'b0;
            freq_reg   <= CENTER_WORD;
            update_reg <= 1'b0;
        end else begin
            ev_pending <= ev;
            update_reg <= ev_pending;
            if (ev) begin
                prop_reg  <= prop_next;
                integ_reg <= integ_next;
            end
            if (ev_pending)
                freq_reg <= freq_next;
        end
    end

    assign lf.freq_word   = freq_reg;
    assign lf.freq_update = update_reg;
    assign lf.integ_out   = integ_reg;

`ifdef LF_LOCK_DET_EN
    localparam int unsigned      CW = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0]    LC = CW'(LOCK_COUNT);

    logic [CW-1:0] lock_cnt;
    logic [CW-1:0] cnt_next;
    logic [1:0]    last_sign;
    logic [1:0]    cur_sign;
    logic          opposite;
    logic          locked_reg;

    // last_sign: 00 = no event yet, 01 = positive, 11 = negative
    always_comb begin
        cur_sign = lf.phase_error[15] ? 2'b11 : 2'b01;
        opposite = (last_sign != 2'b00) && (last_sign != cur_sign);
        if (!opposite)
            cnt_next = '0;
        else if (lock_cnt == LC)
            cnt_next = lock_cnt;
        else
            cnt_next = lock_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt   <= '0;
            last_sign  <= 2'b00;
            locked_reg <= 1'b0;
        end else if (ev) begin
            lock_cnt   <= cnt_next;
            last_sign  <= cur_sign;
            locked_reg <= (cnt_next == LC);
        end
    end

    assign lf.locked = locked_reg;
`else
    assign lf.locked = 1'b0;
`endif

endmodule

// File: tb/tb_dpll_loop_filter.sv
// Directed bench for dpll_loop_filter: table-driven main sequence plus
// hand-written clamp, reset-mid-pipeline and lock-detector sequences.
module tb_dpll_loop_filter;
    localparam logic [31:0] C_WORD   = 32'd85899346;
    localparam logic [31:0] F_MAX    = 32'd171798692;
`ifdef LF_LOCK_DET_EN
    localparam bit          LOCK_EN  = 1'b1;
`else
    localparam bit          LOCK_EN  = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic signed [15:0] pe;
    logic               hold;

    always #5 clk = ~clk;

    dpll_loop_filter_if if_def ();
    dpll_loop_filter_if if_lim ();
    dpll_loop_filter_if if_hi ();
    dpll_loop_filter_if if_lck ();

    assign if_def.phase_error = pe;
    assign if_def.hold        = hold;
    assign if_lim.phase_error = pe;
    assign if_lim.hold        = hold;
    assign if_hi.phase_error  = pe;
    assign if_hi.hold         = hold;
    assign if_lck.phase_error = pe;
    assign if_lck.hold        = hold;

    dpll_loop_filter u_def (.clk(clk), .reset_n(reset_n), .lf(if_def));
    dpll_loop_filter #(.INT_LIMIT(32'd16)) u_lim (.clk(clk), .reset_n(reset_n), .lf(if_lim));
    dpll_loop_filter #(.CENTER_WORD(F_MAX - 32'd100), .INT_LIMIT(32'd16))
        u_hi (.clk(clk), .reset_n(reset_n), .lf(if_hi));
    dpll_loop_filter #(.LOCK_COUNT(4)) u_lck (.clk(clk), .reset_n(reset_n), .lf(if_lck));

    typedef struct {
        logic signed [15:0] pe;
        logic               hold;
        logic signed [31:0] integ;
        logic        [31:0] fw;
        logic               upd;
    } vec_t;

    vec_t vt [16];
    int   total = 0;
    int   bad   = 0;
    int   upd_cnt = 0;

    always @(negedge clk) if (if_def.freq_update === 1'b1) upd_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Inputs are set at a falling edge; outputs are valid at the next falling edge
    task automatic cyc(input logic signed [15:0] p, input logic h);
        pe   = p;
        hold = h;
        @(negedge clk);
    endtask

    task automatic do_reset();
        pe      = '0;
        hold    = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        vt[0]  = '{16'sd0,      1'b0, 32'sd0,       32'd85899346, 1'b0};
        vt[1]  = '{16'sd1,      1'b0, 32'sd4,       32'd85899346, 1'b0};
        vt[2]  = '{16'sd0,      1'b0, 32'sd4,       32'd85899606, 1'b1};
        vt[3]  = '{-16'sd1,     1'b0, 32'sd0,       32'd85899606, 1'b0};
        vt[4]  = '{16'sd0,      1'b0, 32'sd0,       32'd85899090, 1'b1};
        vt[5]  = '{16'sd1,      1'b1, 32'sd0,       32'd85899090, 1'b0};
        vt[6]  = '{16'sd1,      1'b1, 32'sd0,       32'd85899090, 1'b0};
        vt[7]  = '{16'sd0,      1'b0, 32'sd0,       32'd85899090, 1'b0};
        vt[8]  = '{16'sd2,      1'b0, 32'sd8,       32'd85899090, 1'b0};
        vt[9]  = '{-16'sd3,     1'b0, -32'sd4,      32'd85899866, 1'b1};
        vt[10] = '{16'sd0,      1'b0, -32'sd4,      32'd85898574, 1'b1};
        vt[11] = '{16'sd1,      1'b0, 32'sd0,       32'd85898574, 1'b0};
        vt[12] = '{16'sd1,      1'b1, 32'sd0,       32'd85899602, 1'b1};
        vt[13] = '{16'sd0,      1'b0, 32'sd0,       32'd85899602, 1'b0};
        vt[14] = '{-16'sd32768, 1'b0, -32'sd131072, 32'd85899602, 1'b0};
        vt[15] = '{16'sd0,      1'b0, -32'sd131072, 32'd77379666, 1'b1};

        do_reset();
        chk("reset_freq_word", if_def.freq_word, C_WORD);
        chk("reset_update", {31'd0, if_def.freq_update}, 32'd0);
        chk("reset_integ", if_def.integ_out, 32'd0);
        chk("reset_locked", {31'd0, if_lck.locked}, 32'd0);

        upd_cnt = 0;
        repeat (20) cyc(16'sd0, 1'b0);
        chk("idle_updates", upd_cnt, 32'd0);
        chk("idle_freq_word", if_def.freq_word, C_WORD);
        chk("idle_integ", if_def.integ_out, 32'd0);

        for (int i = 0; i < 16; i++) begin
            cyc(vt[i].pe, vt[i].hold);
            chk($sformatf("vec%0d_integ", i), if_def.integ_out, vt[i].integ);
            chk($sformatf("vec%0d_freq", i), if_def.freq_word, vt[i].fw);
            chk($sformatf("vec%0d_upd", i), {31'd0, if_def.freq_update}, {31'd0, vt[i].upd});
        end

        // Reset asserted while a stage-2 reload is pending
        do_reset();
        cyc(16'sd1, 1'b0);
        pe      = '0;
        reset_n = 1'b0;
        #1;
        chk("midrst_freq_now", if_def.freq_word, C_WORD);
        chk("midrst_integ_now", if_def.integ_out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        upd_cnt = 0;
        repeat (5) cyc(16'sd0, 1'b0);
        chk("midrst_no_update", upd_cnt, 32'd0);
        chk("midrst_freq_after", if_def.freq_word, C_WORD);

        // Integrator clamp at INT_LIMIT = 16
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(16'sd1, 1'b0);
            chk($sformatf("lim_integ%0d", i), if_lim.integ_out, (i < 4) ? 32'(4 * (i + 1)) : 32'd16);
        end
        cyc(16'sd0, 1'b0);
        chk("lim_freq_final", if_lim.freq_word, 32'd85899618);

        // freq_word clamp at FREQ_MAX, then back down with integrator at -16
        do_reset();
        cyc(16'sd1, 1'b0);
        cyc(16'sd0, 1'b0);
        chk("hi_freq_clamped", if_hi.freq_word, F_MAX);
        for (int i = 0; i < 5; i++) cyc(-16'sd1, 1'b0);
        cyc(16'sd0, 1'b0);
        chk("hi_integ_neg", if_hi.integ_out, -32'sd16);
        chk("hi_freq_final", if_hi.freq_word, F_MAX - 32'd100 - 32'd256 - 32'd16);
        cyc(-16'sd1, 1'b0);
        chk("lim_integ_negclamp", if_lim.integ_out, -32'sd16);

        // Lock detector with LOCK_COUNT = 4; tied low when the feature is not built
        do_reset();
        begin
            logic signed [15:0] lp [7];
            logic               lh [7];
            logic               le [7];
            lp = '{16'sd1, -16'sd1, 16'sd1, -16'sd1, 16'sd1, 16'sd1, 16'sd1};
            lh = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            le = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 7; i++) begin
                cyc(lp[i], lh[i]);
                chk($sformatf("lock_ev%0d", i), {31'd0, if_lck.locked}, {31'd0, le[i] & LOCK_EN});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
